core_sequencer: RTL and testbench
=================================

CORE_SEQUENCER -- requirements
Module: core_sequencer

Interface
REQ-001 Parameter: TIMEOUT_CYCLES, default 255, max cycles to wait for any memory ack before bus error.
REQ-002 Clock and reset: one clock; reset is asynchronous and active-high.
REQ-003 clk  in  1  system clock, rising edge.
REQ-004 rst  in  1  asynchronous active-high reset.
REQ-005 halt_req  in  1  request to pause at the next instruction boundary.
REQ-006 imem_req  out  1  instruction fetch request.
REQ-007 imem_ack  in  1  fetch data valid this cycle.
REQ-008 ir_we  out  1  instruction register load strobe.
REQ-009 dec_wb_from  in  wb_from_e  decoded write-back source.
REQ-010 dec_mem_op  in  mem_op_e  decoded memory op.
REQ-011 dec_r_we  in  reg_we_e  decoded register write enable.
REQ-012 dec_csr_we  in  reg_we_e  decoded CSR write enable.
REQ-013 dmem_req  out  1  data memory request.
REQ-014 dmem_we  out  1  data memory write (store) qualifier.
REQ-015 dmem_ack  in  1  data access complete this cycle.
REQ-016 rf_we  out  1  register file write strobe.
REQ-017 csr_we  out  1  CSR write strobe.
REQ-018 pc_we  out  1  PC update strobe.
REQ-019 halted  out  1  core paused.
REQ-020 bus_err  out  1  sticky memory-timeout flag.
REQ-021 instret  out  32  retired-instruction count.
REQ-022 state  out  seq_state_e  current state (debug).

Function
REQ-023 States SHALL be IDLE, FETCH, DECODE, EXEC, MEM, WB, HALT, ERR.
REQ-024 IDLE -> HALT if halt_req, else FETCH, after one cycle.
REQ-025 FETCH: imem_req=1 held until imem_ack; on ack cycle ir_we=1 (combinational on ack) and next state DECODE.
REQ-026 DECODE: single cycle, all strobes 0, -> EXEC.
REQ-027 EXEC: single cycle; -> MEM if dec_wb_from==WB_MEM or dec_mem_op==MEM_STORE, else -> WB.
REQ-028 MEM: dmem_req=1, dmem_we=(dec_mem_op==MEM_STORE), both held stable until dmem_ack; on ack -> WB.
REQ-029 WB: single cycle; pc_we=1; rf_we=(dec_r_we==REG_WE); csr_we=(dec_csr_we==REG_WE); instret increments by 1, wrapping 0xFFFFFFFF -> 0.
REQ-030 WB -> HALT if halt_req, else FETCH.
REQ-031 HALT: halted=1, no requests; -> FETCH on first cycle halt_req==0.
REQ-032 halt_req asserted mid-instruction SHALL NOT abort it; honoured only at WB or IDLE.
REQ-033 Wait counter SHALL clear on entry to FETCH/MEM and count each cycle without ack; reaching TIMEOUT_CYCLES without ack -> ERR.
REQ-034 Ack in the same cycle the counter reaches TIMEOUT_CYCLES: ack wins, normal transition.
REQ-035 ERR: bus_err=1, all strobes/requests 0, terminal until rst.
REQ-036 Strobes other than ir_we SHALL be Moore outputs decoded from state; at most one of imem_req/dmem_req high per cycle.
REQ-037 Acks arriving outside FETCH/MEM SHALL be ignored.

Reset
REQ-038 On rst: state=IDLE, instret=0, wait counter=0, bus_err=0, all other outputs 0.
REQ-039 rst asserted mid-access SHALL drop imem_req/dmem_req asynchronously; no retire, no instret change.

Structure
REQ-040 seq_state_e and the default timeout constant SHALL live in the shared rv32i package.
REQ-041 Watchdog counter SHALL be a sub-module seq_timer (clear, enable, expired).

Verification
REQ-042 ADDI, imem_ack after 2 wait cycles -> FETCH(3 cycles) DECODE EXEC WB; rf_we=1 one cycle; instret 0->1.
REQ-043 SW (MEM_STORE, r_we=REG_WD), dmem_ack after 3 cycles -> dmem_we=1 held 4 cycles; rf_we=0 in WB; pc_we=1.
REQ-044 LW (WB_MEM) with halt_req raised in EXEC -> completes WB, enters HALT, halted=1; release -> FETCH next cycle.
REQ-045 No imem_ack for 255 cycles -> ERR, bus_err=1 sticky; ack at exactly cycle 255 in a second run -> DECODE.
REQ-046 instret preloaded-equivalent at 0xFFFFFFFF (via 2^32 retires or forced) + one WB -> 0x00000000.
REQ-047 rst pulsed during MEM -> dmem_req 0 immediately, state IDLE, instret unchanged.

Source files
------------

// File: rtl/rv32i_pkg.sv
// Shared types for the rv32i core: decode fields, sequencer states and the
// default memory-ack timeout.
package rv32i_pkg;

    localparam int DEFAULT_TIMEOUT_CYCLES = 255;

    typedef enum logic [1:0] {
        WB_ALU = 2'd0,
        WB_MEM = 2'd1,
        WB_PC4 = 2'd2,
        WB_CSR = 2'd3
    } wb_from_e;

    typedef enum logic [1:0] {
        MEM_NONE  = 2'd0,
        MEM_LOAD  = 2'd1,
        MEM_STORE = 2'd2
    } mem_op_e;

    typedef enum logic {
        REG_WD = 1'b0,
        REG_WE = 1'b1
    } reg_we_e;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FETCH  = 3'd1,
        DECODE = 3'd2,
        EXEC   = 3'd3,
        MEM    = 3'd4,
        WB     = 3'd5,
        HALT   = 3'd6,
        ERR    = 3'd7
    } seq_state_e;

    // Loads need the data phase for their write-back value; stores need it to write.
    function automatic logic needs_mem(input wb_from_e wb_from, input mem_op_e mem_op);
        return (wb_from == WB_MEM) || (mem_op == MEM_STORE);
    endfunction

endpackage

// File: rtl/seq_timer.sv
// Watchdog for memory handshakes: counts wait cycles and flags the cycle in
// which the TIMEOUT_CYCLES-th consecutive cycle without an ack is reached.
module seq_timer #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [W-1:0] LAST = W'(TIMEOUT_CYCLES - 1);

    logic [W-1:0] count;

    // NOTE: sequential state is written with <= so every flop samples the
    // pre-edge values; blocking here would create order-dependent behaviour.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && !expired) begin
            count <= count + 1'b1;
        end
    end

    // count holds the number of wait cycles already elapsed, so equality with
    // LAST means the current cycle is the final one allowed.
    assign expired = (count == LAST);

endmodule

// File: rtl/core_sequencer.sv
// Multi-cycle instruction sequencer: fetch, decode, execute, optional data
// access and write-back, with halt handling and a sticky bus-timeout error.
module core_sequencer
    import rv32i_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        halt_req,
    output logic        imem_req,
    input  logic        imem_ack,
    output logic        ir_we,
    input  wb_from_e    dec_wb_from,
    input  mem_op_e     dec_mem_op,
    input  reg_we_e     dec_r_we,
    input  reg_we_e     dec_csr_we,
    output logic        dmem_req,
    output logic        dmem_we,
    input  logic        dmem_ack,
    output logic        rf_we,
    output logic        csr_we,
    output logic        pc_we,
    output logic        halted,
    output logic        bus_err,
    output logic [31:0] instret,
    output seq_state_e  state
);

    seq_state_e  state_q;
    seq_state_e  next_state;
    logic [31:0] instret_q;
    logic        timer_clear;
    logic        timer_enable;
    logic        timer_expired;

    seq_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timer (
        .clk    (clk),
        .rst    (rst),
        .clear  (timer_clear),
        .enable (timer_enable),
        .expired(timer_expired)
    );

    // Restart the watchdog on every fresh entry into a waiting state.
    assign timer_clear  = (next_state != state_q) &&
                          ((next_state == FETCH) || (next_state == MEM));
    assign timer_enable = ((state_q == FETCH) && !imem_ack) ||
                          ((state_q == MEM)   && !dmem_ack);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= next_state;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            instret_q <= '0;
        end else if (state_q == WB) begin
            instret_q <= instret_q + 32'd1;
        end
    end

    always_comb begin
        // NOTE: every output of this block gets a default before the case, so
        // no path leaves a signal unassigned and no latch is inferred.
        next_state = state_q;
        imem_req   = 1'b0;
        ir_we      = 1'b0;
        dmem_req   = 1'b0;
        dmem_we    = 1'b0;
        rf_we      = 1'b0;
        csr_we     = 1'b0;
        pc_we      = 1'b0;
        halted     = 1'b0;
        bus_err    = 1'b0;

        case (state_q)
            IDLE: begin
                next_state = halt_req ? HALT : FETCH;
            end
            FETCH: begin
                imem_req = 1'b1;
                if (imem_ack) begin
                    ir_we      = 1'b1;
                    next_state = DECODE;
                end else if (timer_expired) begin
                    next_state = ERR;
                end
            end
            DECODE: begin
                next_state = EXEC;
            end
            EXEC: begin
                next_state = needs_mem(dec_wb_from, dec_mem_op) ? MEM : WB;
            end
            MEM: begin
                dmem_req = 1'b1;
                dmem_we  = (dec_mem_op == MEM_STORE);
                if (dmem_ack) begin
                    next_state = WB;
                end else if (timer_expired) begin
                    next_state = ERR;
                end
            end
            WB: begin
                pc_we      = 1'b1;
                rf_we      = (dec_r_we == REG_WE);
                csr_we     = (dec_csr_we == REG_WE);
                next_state = halt_req ? HALT : FETCH;
            end
            HALT: begin
                halted = 1'b1;
                if (!halt_req) begin
                    next_state = FETCH;
                end
            end
            ERR: begin
                bus_err = 1'b1;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    assign state   = state_q;
    assign instret = instret_q;

endmodule

// File: tb/tb_core_sequencer.sv
// Directed bench for core_sequencer: instruction flows, halt, timeout,
// instret wrap and reset during a data access.
module tb_core_sequencer;
    import rv32i_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        halt_req = 1'b0;
    logic        imem_ack = 1'b0;
    logic        dmem_ack = 1'b0;
    wb_from_e    dec_wb_from = WB_ALU;
    mem_op_e     dec_mem_op = MEM_NONE;
    reg_we_e     dec_r_we = REG_WD;
    reg_we_e     dec_csr_we = REG_WD;
    logic        imem_req, ir_we, dmem_req, dmem_we;
    logic        rf_we, csr_we, pc_we, halted, bus_err;
    logic [31:0] instret;
    seq_state_e  state;

    int tests_run = 0;
    int tests_failed = 0;

    core_sequencer #(.TIMEOUT_CYCLES(255)) dut (
        .clk        (clk),
        .rst        (rst),
        .halt_req   (halt_req),
        .imem_req   (imem_req),
        .imem_ack   (imem_ack),
        .ir_we      (ir_we),
        .dec_wb_from(dec_wb_from),
        .dec_mem_op (dec_mem_op),
        .dec_r_we   (dec_r_we),
        .dec_csr_we (dec_csr_we),
        .dmem_req   (dmem_req),
        .dmem_we    (dmem_we),
        .dmem_ack   (dmem_ack),
        .rf_we      (rf_we),
        .csr_we     (csr_we),
        .pc_we      (pc_we),
        .halted     (halted),
        .bus_err    (bus_err),
        .instret    (instret),
        .state      (state)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic set_dec(input wb_from_e wb, input mem_op_e op, input reg_we_e r, input reg_we_e c);
        dec_wb_from = wb;
        dec_mem_op  = op;
        dec_r_we    = r;
        dec_csr_we  = c;
    endtask

    // Starts in the first FETCH cycle; leaves the bench in DECODE.
    task automatic do_fetch(input int waits, input string tag);
        for (int i = 0; i < waits; i++) begin
            check({tag, "_fetch_state"}, 32'(state), 32'(FETCH));
            check({tag, "_imem_req"}, 32'(imem_req), 32'd1);
            check({tag, "_ir_we_wait"}, 32'(ir_we), 32'd0);
            step();
        end
        imem_ack = 1'b1;
        settle();
        check({tag, "_ack_state"}, 32'(state), 32'(FETCH));
        check({tag, "_ir_we_ack"}, 32'(ir_we), 32'd1);
        step();
        imem_ack = 1'b0;
        check({tag, "_decode"}, 32'(state), 32'(DECODE));
    endtask

    initial begin
        set_dec(WB_ALU, MEM_NONE, REG_WE, REG_WD);
        repeat (2) @(posedge clk);
        #1;
        check("rst_state", 32'(state), 32'(IDLE));
        check("rst_instret", instret, 32'd0);
        check("rst_imem_req", 32'(imem_req), 32'd0);
        check("rst_bus_err", 32'(bus_err), 32'd0);
        check("rst_halted", 32'(halted), 32'd0);
        rst = 1'b0;
        step();
        check("idle_to_fetch", 32'(state), 32'(FETCH));

        // ADDI with two fetch wait cycles; stray acks in DECODE are ignored.
        do_fetch(2, "addi");
        imem_ack = 1'b1;
        dmem_ack = 1'b1;
        settle();
        check("addi_dec_ir_we", 32'(ir_we), 32'd0);
        check("addi_dec_dmem_req", 32'(dmem_req), 32'd0);
        step();
        imem_ack = 1'b0;
        dmem_ack = 1'b0;
        check("addi_exec", 32'(state), 32'(EXEC));
        check("addi_exec_rf_we", 32'(rf_we), 32'd0);
        step();
        check("addi_wb", 32'(state), 32'(WB));
        check("addi_wb_rf_we", 32'(rf_we), 32'd1);
        check("addi_wb_pc_we", 32'(pc_we), 32'd1);
        check("addi_wb_csr_we", 32'(csr_we), 32'd0);
        check("addi_wb_instret", instret, 32'd0);
        step();
        check("addi_next_fetch", 32'(state), 32'(FETCH));
        check("addi_rf_we_off", 32'(rf_we), 32'd0);
        check("addi_instret", instret, 32'd1);

        // SW: data ack after three wait cycles, dmem_we held four cycles.
        set_dec(WB_ALU, MEM_STORE, REG_WD, REG_WD);
        do_fetch(0, "sw");
        step();
        check("sw_exec", 32'(state), 32'(EXEC));
        step();
        for (int i = 0; i < 3; i++) begin
            check("sw_mem_state", 32'(state), 32'(MEM));
            check("sw_dmem_req", 32'(dmem_req), 32'd1);
            check("sw_dmem_we", 32'(dmem_we), 32'd1);
            check("sw_no_imem_req", 32'(imem_req), 32'd0);
            step();
        end
        dmem_ack = 1'b1;
        settle();
        check("sw_dmem_we_ack", 32'(dmem_we), 32'd1);
        step();
        dmem_ack = 1'b0;
        check("sw_wb", 32'(state), 32'(WB));
        check("sw_wb_rf_we", 32'(rf_we), 32'd0);
        check("sw_wb_pc_we", 32'(pc_we), 32'd1);
        check("sw_wb_dmem_req", 32'(dmem_req), 32'd0);
        step();
        check("sw_instret", instret, 32'd2);

        // LW with halt raised in EXEC: finishes, then halts.
        set_dec(WB_MEM, MEM_LOAD, REG_WE, REG_WD);
        do_fetch(1, "lw");
        step();
        check("lw_exec", 32'(state), 32'(EXEC));
        halt_req = 1'b1;
        step();
        check("lw_mem", 32'(state), 32'(MEM));
        check("lw_dmem_we", 32'(dmem_we), 32'd0);
        check("lw_not_halted", 32'(halted), 32'd0);
        dmem_ack = 1'b1;
        step();
        dmem_ack = 1'b0;
        check("lw_wb", 32'(state), 32'(WB));
        check("lw_wb_rf_we", 32'(rf_we), 32'd1);
        step();
        check("lw_halt", 32'(state), 32'(HALT));
        check("lw_halted", 32'(halted), 32'd1);
        check("lw_halt_imem_req", 32'(imem_req), 32'd0);
        check("lw_instret", instret, 32'd3);
        step();
        check("lw_halt_hold", 32'(state), 32'(HALT));
        halt_req = 1'b0;
        step();
        check("lw_release_fetch", 32'(state), 32'(FETCH));
        check("lw_release_halted", 32'(halted), 32'd0);

        // Fetch timeout: 255 cycles without ack.
        set_dec(WB_ALU, MEM_NONE, REG_WE, REG_WD);
        repeat (254) step();
        check("to_cycle255_fetch", 32'(state), 32'(FETCH));
        check("to_cycle255_req", 32'(imem_req), 32'd1);
        step();
        check("to_err", 32'(state), 32'(ERR));
        check("to_bus_err", 32'(bus_err), 32'd1);
        check("to_err_imem_req", 32'(imem_req), 32'd0);
        imem_ack = 1'b1;
        dmem_ack = 1'b1;
        repeat (3) step();
        imem_ack = 1'b0;
        dmem_ack = 1'b0;
        check("to_err_sticky", 32'(state), 32'(ERR));
        check("to_bus_err_sticky", 32'(bus_err), 32'd1);
        check("to_instret_hold", instret, 32'd3);

        // Second run: ack on exactly the 255th cycle wins.
        rst = 1'b1;
        settle();
        check("rst2_state", 32'(state), 32'(IDLE));
        check("rst2_bus_err", 32'(bus_err), 32'd0);
        step();
        rst = 1'b0;
        step();
        check("ack255_fetch", 32'(state), 32'(FETCH));
        repeat (254) step();
        imem_ack = 1'b1;
        settle();
        check("ack255_state", 32'(state), 32'(FETCH));
        check("ack255_ir_we", 32'(ir_we), 32'd1);
        step();
        imem_ack = 1'b0;
        check("ack255_decode", 32'(state), 32'(DECODE));
        check("ack255_bus_err", 32'(bus_err), 32'd0);

        // instret wrap from 0xFFFFFFFF.
        set_dec(WB_ALU, MEM_NONE, REG_WE, REG_WE);
        dut.instret_q = 32'hFFFF_FFFF;
        settle();
        check("wrap_preload", instret, 32'hFFFF_FFFF);
        step();
        step();
        check("wrap_wb", 32'(state), 32'(WB));
        check("wrap_csr_we", 32'(csr_we), 32'd1);
        step();
        check("wrap_instret", instret, 32'd0);

        // Reset during MEM drops the request at once with no retire.
        set_dec(WB_ALU, MEM_STORE, REG_WD, REG_WD);
        do_fetch(0, "rmem");
        step();
        step();
        step();
        check("rmem_mem", 32'(state), 32'(MEM));
        check("rmem_dmem_req", 32'(dmem_req), 32'd1);
        rst = 1'b1;
        settle();
        check("rmem_dmem_req_off", 32'(dmem_req), 32'd0);
        check("rmem_dmem_we_off", 32'(dmem_we), 32'd0);
        check("rmem_state", 32'(state), 32'(IDLE));
        check("rmem_pc_we", 32'(pc_we), 32'd0);
        check("rmem_instret", instret, 32'd0);
        step();
        rst = 1'b0;

        // Halt requested while IDLE.
        halt_req = 1'b1;
        step();
        check("idle_halt", 32'(state), 32'(HALT));
        check("idle_halted", 32'(halted), 32'd1);
        halt_req = 1'b0;
        step();
        check("idle_halt_release", 32'(state), 32'(FETCH));

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
